vending_fsm_param: RTL and testbench

VENDING_FSM_PARAM -- requirements
Module: vending_fsm_param

---
 rtl/vending_fsm_param.sv | 153 +++++++++++++++
 tb/tb_vending_fsm_param.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_fsm_param.sv
// rtl/vending_fsm_param.sv - parameterised coin-operated vending controller
// Tick-enabled FSM with credit accounting, per-unit change return and coin rejection.
module vending_fsm_param #(
  parameter int CREDIT_W = 4,
  parameter int N_PROD = 2,
  parameter int COIN0_VAL = 1,
  parameter int COIN1_VAL = 2,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES = {4'd5, 4'd3},
  parameter int MAX_CREDIT = 9,
  parameter bit AUTO_CHANGE = 1'b1,
  localparam int PROD_W = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [1:0]          coin,
  input  logic [N_PROD-1:0]   sel,
  input  logic                cancel,
  output logic                dispense,
  output logic [PROD_W-1:0]   prod,
  output logic                change,
  output logic                coin_reject,
  output logic                deny,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int W = CREDIT_W + 1;

  typedef enum logic [1:0] {S_CREDIT, S_VEND, S_CHANGE, S_REFUND} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [1:0]          coin_prev_q, coin_prev_d;
  logic                dispense_q, dispense_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic                change_q, change_d;
  logic                coin_reject_q, coin_reject_d;
  logic                deny_q, deny_d;
  logic                busy_q, busy_d;

  logic [1:0]          coin_edge;
  logic [W-1:0]        coin_sum;
  logic                sel_onehot;
  logic [PROD_W-1:0]   sel_idx;
  logic [CREDIT_W-1:0] sel_price;

  assign coin_edge  = coin & ~coin_prev_q;
  assign coin_sum   = (coin_edge[0] ? W'(COIN0_VAL) : '0) + (coin_edge[1] ? W'(COIN1_VAL) : '0);
  assign sel_onehot = $onehot(sel);

  always_comb begin
    sel_idx   = '0;
    sel_price = '0;
    for (int i = 0; i < N_PROD; i++) begin
      if (sel[i]) begin
        sel_idx   = PROD_W'(i);
        sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    coin_prev_d   = coin_prev_q;
    dispense_d    = dispense_q;
    prod_d        = prod_q;
    change_d      = change_q;
    coin_reject_d = coin_reject_q;
    deny_d        = deny_q;
    busy_d        = busy_q;
    if (tick) begin
      coin_prev_d   = coin;
      dispense_d    = 1'b0;
      prod_d        = '0;
      change_d      = 1'b0;
      coin_reject_d = 1'b0;
      deny_d        = 1'b0;
      case (state_q)
        S_CREDIT: begin
          if (cancel && credit_q != '0) begin
            state_d       = S_REFUND;
            coin_reject_d = |coin_edge;
          end else if (sel_onehot && credit_q >= sel_price) begin
            credit_d      = credit_q - sel_price;
            prod_d        = sel_idx;
            dispense_d    = 1'b1;
            state_d       = S_VEND;
            coin_reject_d = |coin_edge;
          end else begin
            deny_d = sel_onehot;
            // Headroom is computed as MAX - credit so the sum never needs an extra bit.
            if (|coin_edge) begin
              if (coin_sum > W'(MAX_CREDIT) - W'(credit_q)) begin
                coin_reject_d = 1'b1;
              end else begin
                credit_d = CREDIT_W'(W'(credit_q) + coin_sum);
              end
            end
          end
        end
        S_VEND: begin
          coin_reject_d = |coin_edge;
          state_d = (AUTO_CHANGE && credit_q != '0) ? S_CHANGE : S_CREDIT;
        end
        default: begin
          coin_reject_d = |coin_edge;
          if (credit_q != '0) begin
            change_d = 1'b1;
            credit_d = credit_q - CREDIT_W'(1);
          end else begin
            state_d = S_CREDIT;
          end
        end
      endcase
      busy_d = (state_d != S_CREDIT);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_CREDIT;
      credit_q      <= '0;
      coin_prev_q   <= '0;
      dispense_q    <= 1'b0;
      prod_q        <= '0;
      change_q      <= 1'b0;
      coin_reject_q <= 1'b0;
      deny_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      coin_prev_q   <= coin_prev_d;
      dispense_q    <= dispense_d;
      prod_q        <= prod_d;
      change_q      <= change_d;
      coin_reject_q <= coin_reject_d;
      deny_q        <= deny_d;
      busy_q        <= busy_d;
    end
  end

  assign dispense    = dispense_q;
  assign prod        = prod_q;
  assign change      = change_q;
  assign coin_reject = coin_reject_q;
  assign deny        = deny_q;
  assign credit      = credit_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vending_fsm_param.sv
// tb/tb_vending_fsm_param.sv - vending_fsm_param bench, AUTO_CHANGE=1 and AUTO_CHANGE=0 instances
// Reference model predicts each busy period as a precomputed schedule of per-tick outputs.
module tb_vending_fsm_param;

  localparam int C0 = 1;
  localparam int C1 = 2;
  localparam int MAXC = 9;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       cancel = 1'b0;
  logic [1:0] coin = 2'b00;
  logic [1:0] sel = 2'b00;

  logic [1:0] dispense_w, prod_w, change_w, rej_w, deny_w, busy_w;
  logic [3:0] credit_w [2];

  always #5 clk = ~clk;

  vending_fsm_param u_ac1 (
    .clk(clk), .reset(reset), .tick(tick), .coin(coin), .sel(sel), .cancel(cancel),
    .dispense(dispense_w[0]), .prod(prod_w[0]), .change(change_w[0]),
    .coin_reject(rej_w[0]), .deny(deny_w[0]), .credit(credit_w[0]), .busy(busy_w[0])
  );

  vending_fsm_param #(.AUTO_CHANGE(1'b0)) u_ac0 (
    .clk(clk), .reset(reset), .tick(tick), .coin(coin), .sel(sel), .cancel(cancel),
    .dispense(dispense_w[1]), .prod(prod_w[1]), .change(change_w[1]),
    .coin_reject(rej_w[1]), .deny(deny_w[1]), .credit(credit_w[1]), .busy(busy_w[1])
  );

  typedef struct packed {
    logic       busy;
    logic       chg;
    logic [7:0] cr;
  } ev_t;

  ev_t        q0[$];
  ev_t        q1[$];
  int         m_cr [2];
  logic [1:0] m_prev [2];
  int         x_disp [2], x_prod [2], x_chg [2], x_rej [2], x_deny [2], x_busy [2];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input int exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int price(input int i);
    return (i == 0) ? 3 : 5;
  endfunction

  function automatic int qsize(input int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int m, input ev_t e);
    if (m == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic qpop(input int m, output ev_t e);
    if (m == 0) e = q0.pop_front();
    else e = q1.pop_front();
  endtask

  // Returning c units: c ticks each pulsing change, then one tick back to idle.
  task automatic sched_return(input int m, input int c);
    for (int k = c - 1; k >= 0; k--) qpush(m, '{busy: 1'b1, chg: 1'b1, cr: 8'(k)});
    qpush(m, '{busy: 1'b0, chg: 1'b0, cr: 8'd0});
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int m = 0; m < 2; m++) begin
      m_cr[m] = 0; m_prev[m] = 2'b00;
      x_disp[m] = 0; x_prod[m] = 0; x_chg[m] = 0; x_rej[m] = 0; x_deny[m] = 0; x_busy[m] = 0;
    end
  endtask

  task automatic model_step(input int m);
    logic [1:0] e;
    int         sum, r, idx;
    bit         any, accepted;
    ev_t        ev;
    e   = coin & ~m_prev[m];
    any = (e != 2'b00);
    sum = (e[0] ? C0 : 0) + (e[1] ? C1 : 0);
    x_disp[m] = 0; x_prod[m] = 0; x_chg[m] = 0; x_rej[m] = 0; x_deny[m] = 0;
    if (qsize(m) > 0) begin
      qpop(m, ev);
      x_busy[m] = ev.busy;
      x_chg[m]  = ev.chg;
      m_cr[m]   = ev.cr;
      x_rej[m]  = any;
    end else begin
      accepted  = 0;
      x_busy[m] = 0;
      if (cancel && m_cr[m] > 0) begin
        accepted  = 1;
        x_busy[m] = 1;
        sched_return(m, m_cr[m]);
      end else if ($countones(sel) == 1) begin
        idx = sel[1] ? 1 : 0;
        if (m_cr[m] >= price(idx)) begin
          r = m_cr[m] - price(idx);
          m_cr[m] = r;
          accepted  = 1;
          x_disp[m] = 1;
          x_prod[m] = idx;
          x_busy[m] = 1;
          if (m == 0 && r > 0) begin
            qpush(m, '{busy: 1'b1, chg: 1'b0, cr: 8'(r)});
            sched_return(m, r);
          end else begin
            qpush(m, '{busy: 1'b0, chg: 1'b0, cr: 8'(r)});
          end
        end else begin
          x_deny[m] = 1;
        end
      end
      if (accepted) x_rej[m] = any;
      else if (any) begin
        if (m_cr[m] + sum > MAXC) x_rej[m] = 1;
        else m_cr[m] = m_cr[m] + sum;
      end
    end
    m_prev[m] = coin;
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("dispense[%0d]", m), dispense_w[m], x_disp[m]);
      if (x_disp[m] != 0) check($sformatf("prod[%0d]", m), prod_w[m], x_prod[m]);
      check($sformatf("change[%0d]", m), change_w[m], x_chg[m]);
      check($sformatf("coin_reject[%0d]", m), rej_w[m], x_rej[m]);
      check($sformatf("deny[%0d]", m), deny_w[m], x_deny[m]);
      check($sformatf("credit[%0d]", m), credit_w[m], m_cr[m]);
      check($sformatf("busy[%0d]", m), busy_w[m], x_busy[m]);
    end
  endtask

  // Called at a falling edge; inputs settle before the next rising edge.
  task automatic cyc(input logic t, input logic [1:0] c, input logic [1:0] s, input logic x);
    tick = t; coin = c; sel = s; cancel = x;
    if (t) begin
      model_step(0);
      model_step(1);
    end
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic coins_to(input int n1, input int n0);
    for (int i = 0; i < n1; i++) begin
      cyc(1, 2'b10, 2'b00, 0);
      cyc(1, 2'b00, 2'b00, 0);
    end
    for (int i = 0; i < n0; i++) begin
      cyc(1, 2'b01, 2'b00, 0);
      cyc(1, 2'b00, 2'b00, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b1;

    coins_to(2, 0);
    check("basic_credit4", credit_w[0], 4);
    cyc(1, 2'b00, 2'b01, 0);
    check("basic_dispense", dispense_w[0], 1);
    check("basic_credit1", credit_w[0], 1);
    cyc(1, 2'b00, 2'b00, 0);
    cyc(1, 2'b00, 2'b00, 0);
    check("basic_change", change_w[0], 1);
    cyc(1, 2'b00, 2'b00, 0);
    check("basic_idle_busy", busy_w[0], 0);
    do_reset();

    coins_to(1, 1);
    cyc(1, 2'b00, 2'b10, 0);
    check("deny_pulse", deny_w[0], 1);
    check("deny_credit", credit_w[0], 3);
    cyc(1, 2'b00, 2'b00, 1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 2'b00, 2'b00, 0);
      cnt += change_w[0];
    end
    check("refund_pulses", cnt, 3);
    check("refund_credit", credit_w[0], 0);
    do_reset();

    coins_to(4, 0);
    cyc(1, 2'b10, 2'b00, 0);
    check("ceiling_reject", rej_w[0], 1);
    check("ceiling_credit", credit_w[0], 8);
    do_reset();
    coins_to(3, 0);
    cyc(1, 2'b11, 2'b00, 0);
    check("dual_coin_credit9", credit_w[0], 9);
    do_reset();

    coins_to(3, 1);
    cyc(1, 2'b00, 2'b01, 0);
    check("noac_credit4", credit_w[1], 4);
    cyc(1, 2'b01, 2'b00, 0);
    check("noac_vend_reject", rej_w[1], 1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 2'b00, 2'b00, 0);
      cnt += change_w[1];
    end
    check("noac_no_change", cnt, 0);
    check("noac_keep_credit", credit_w[1], 4);
    do_reset();

    coins_to(4, 0);
    cyc(1, 2'b00, 2'b01, 0);
    cyc(1, 2'b00, 2'b00, 0);
    cyc(1, 2'b00, 2'b00, 0);
    cyc(1, 2'b00, 2'b00, 0);
    check("mid_change_credit3", credit_w[0], 3);
    do_reset();
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 2'b00, 2'b00, 0);
      cnt += change_w[0];
    end
    check("post_reset_no_change", cnt, 0);

    for (int i = 0; i < 12; i++) cyc((i % 4) == 0, 2'b01, 2'b00, 0);
    check("slow_tick_one_coin", credit_w[0], 1);
    cyc(1, 2'b00, 2'b00, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc($urandom_range(0, 3) != 0, 2'($urandom), 2'($urandom), $urandom_range(0, 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
